// File: rtl/branch_predict_unit_if.sv
// Signal bundle between the IF/EX pipeline and the branch predictor.
// The master side drives fetch/resolve information; the slave is the predictor.
interface branch_predict_unit_if;
  logic [31:0] if_pc_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_imm_i;
  logic        stall_i;
  logic        flush_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic        ex_mispred_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        id_pred_taken_o;
  logic [31:0] id_pred_target_o;
  logic [31:0] stat_branch_cnt_o;
  logic [31:0] stat_miss_cnt_o;

  // No handshake: IF inputs are sampled combinationally every cycle; an EX
  // update is consumed on the rising edge whenever ex_valid_i is high.
  modport master (
    output if_pc_i, if_instr_i, if_imm_i, stall_i, flush_i,
    output ex_valid_i, ex_pc_i, ex_taken_i, ex_mispred_i,
    input  pred_taken_o, pred_target_o, id_pred_taken_o, id_pred_target_o,
    input  stat_branch_cnt_o, stat_miss_cnt_o
  );

  modport slave (
    input  if_pc_i, if_instr_i, if_imm_i, stall_i, flush_i,
    input  ex_valid_i, ex_pc_i, ex_taken_i, ex_mispred_i,
    output pred_taken_o, pred_target_o, id_pred_taken_o, id_pred_target_o,
    output stat_branch_cnt_o, stat_miss_cnt_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// IF-stage 2-bit saturating-counter branch predictor with IF/ID prediction registers.
// Optional resolved-branch / misprediction statistics enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]       cnt_q [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_cur;
  logic [1:0]       wr_next;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             id_taken_q;
  logic [31:0]      id_target_q;

  assign rd_idx = bus.if_pc_i[IDX_W+1:2];
  assign wr_idx = bus.ex_pc_i[IDX_W+1:2];
  assign wr_cur = cnt_q[wr_idx];

  // Reads see the pre-update table; a same-cycle write shows up next cycle.
  always_comb begin
    pred_taken = 1'b0;
    if (bus.if_instr_i[1:0] == 2'b11) begin
      case (bus.if_instr_i[6:0])
        OP_JAL:    pred_taken = 1'b1;
        OP_BRANCH: pred_taken = cnt_q[rd_idx][1];
        default:   pred_taken = 1'b0;
      endcase
    end
  end

  assign pred_target = bus.if_pc_i + bus.if_imm_i;

  always_comb begin
    wr_next = wr_cur;
    if (bus.ex_taken_i) begin
      if (wr_cur != 2'b11) wr_next = wr_cur + 2'd1;
    end else begin
      if (wr_cur != 2'b00) wr_next = wr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (bus.ex_valid_i) begin
      cnt_q[wr_idx] <= wr_next;
    end
  end

  // Flush beats stall so a redirect can never leave a stale prediction in ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_taken_q  <= 1'b0;
      id_target_q <= 32'h0;
    end else if (bus.flush_i) begin
      id_taken_q  <= 1'b0;
      id_target_q <= 32'h0;
    end else if (!bus.stall_i) begin
      id_taken_q  <= pred_taken;
      id_target_q <= pred_target;
    end
  end

  assign bus.pred_taken_o     = pred_taken;
  assign bus.pred_target_o    = pred_target;
  assign bus.id_pred_taken_o  = id_taken_q;
  assign bus.id_pred_target_o = id_target_q;

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= 32'h0;
      miss_cnt_q   <= 32'h0;
    end else if (bus.ex_valid_i) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (bus.ex_mispred_i && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.stat_branch_cnt_o = branch_cnt_q;
  assign bus.stat_miss_cnt_o   = miss_cnt_q;
`else
  assign bus.stat_branch_cnt_o = 32'h0;
  assign bus.stat_miss_cnt_o   = 32'h0;
`endif

endmodule
